// File: rtl/core_pkg.sv
// Shared hazard-tracking types: instruction hazard classes, ID forwarding select
// codes and the per-stage tracker slot record.
package core_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } optype_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX      = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    typedef struct packed {
        optype_t    optype;
        logic [4:0] rd;
        logic [4:0] rs2;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{optype: OP_NONE, rd: 5'd0, rs2: 5'd0};

    // True when the slot holds a register-writing instruction that produces rs.
    function automatic logic writes_reg(input slot_t s, input logic [4:0] rs);
        return (rs != 5'd0) && (s.rd == rs) &&
               ((s.optype == OP_ALU) || (s.optype == OP_LOAD));
    endfunction

endpackage

// File: rtl/hazard_stage_slot.sv
// One pipeline-stage entry of the hazard tracker; reloaded every cycle, never held.
module hazard_stage_slot
    import core_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= SLOT_EMPTY;
        else     q <= d;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline scheduler: load-use stall, ID-resolved branch squash and ID/MEM
// forwarding selects derived from the EX/MEM/WB tracker slots.
module hazard_unit
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rs1use,
    input  logic       rs2use,
    input  logic [1:0] hazard_optype,
    input  logic [4:0] rd_ID,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       Branch_ID,
    output logic       PC_EN_IF,
    output logic       reg_FD_EN,
    output logic       reg_FD_flush,
    output logic       reg_DE_flush,
    output logic [1:0] forward_ctrl_A,
    output logic [1:0] forward_ctrl_B,
    output logic       forward_ctrl_ls
);

    slot_t   ex_s, mem_s, wb_s, ex_d;
    optype_t id_optype;
    logic    load_stall;
    logic    unused_wb_rs2;

    hazard_stage_slot u_slot_ex  (.clk(clk), .rst(rst), .d(ex_d),  .q(ex_s));
    hazard_stage_slot u_slot_mem (.clk(clk), .rst(rst), .d(ex_s),  .q(mem_s));
    hazard_stage_slot u_slot_wb  (.clk(clk), .rst(rst), .d(mem_s), .q(wb_s));

    assign unused_wb_rs2 = ^wb_s.rs2;

    // An EX load producing this operand falls through to the MEM checks; the
    // stall it raises discards whatever select results.
    function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                           input logic use_rs, input logic [4:0] rs);
        if (!use_rs)                                         return FWD_RF;
        if (ex.optype == OP_ALU && writes_reg(ex, rs))       return FWD_EX;
        if (mem.optype == OP_ALU && writes_reg(mem, rs))     return FWD_MEM_ALU;
        if (mem.optype == OP_LOAD && writes_reg(mem, rs))    return FWD_MEM_LD;
        return FWD_RF;
    endfunction

    assign id_optype = optype_t'(hazard_optype);

    always_comb begin
        load_stall = (ex_s.optype == OP_LOAD) &&
                     ((rs1use && writes_reg(ex_s, rs1_ID)) ||
                      (rs2use && writes_reg(ex_s, rs2_ID) && id_optype != OP_STORE));
        ex_d = load_stall ? SLOT_EMPTY
                          : '{optype: id_optype, rd: rd_ID, rs2: rs2_ID};
    end

    // Outputs are forced to their idle values while reset is held so a branch
    // arriving during reset cannot squash the fetch.
    always_comb begin
        PC_EN_IF        = 1'b1;
        reg_FD_EN       = 1'b1;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        forward_ctrl_A  = FWD_RF;
        forward_ctrl_B  = FWD_RF;
        forward_ctrl_ls = 1'b0;
        if (!rst) begin
            PC_EN_IF        = !load_stall;
            reg_FD_EN       = !load_stall;
            reg_DE_flush    = load_stall;
            reg_FD_flush    = Branch_ID && !load_stall;
            forward_ctrl_A  = fwd_sel(ex_s, mem_s, rs1use, rs1_ID);
            forward_ctrl_B  = fwd_sel(ex_s, mem_s, rs2use, rs2_ID);
            forward_ctrl_ls = (mem_s.optype == OP_STORE) && (wb_s.optype == OP_LOAD) &&
                              (wb_s.rd == mem_s.rs2) && (wb_s.rd != 5'd0);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed test-plan sequences then random
// instruction streams against an instruction-history reference model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs1use, rs2use, Branch_ID;
    logic [1:0] hazard_optype;
    logic [4:0] rd_ID, rs1_ID, rs2_ID;
    logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_ls;
    logic [1:0] forward_ctrl_A, forward_ctrl_B;

    hazard_unit dut (
        .clk(clk), .rst(rst), .rs1use(rs1use), .rs2use(rs2use),
        .hazard_optype(hazard_optype), .rd_ID(rd_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .Branch_ID(Branch_ID), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls)
    );

    always #5 clk = ~clk;

    typedef struct { int op; int rd; int rs2; } ent_t;
    typedef struct { bit r1u; bit r2u; int op; int rd; int rs1; int rs2; bit br; } ins_t;
    typedef struct { bit pc_en; bit fd_en; bit fd_flush; bit de_flush; int fa; int fb; bit ls; } exp_t;

    ent_t hist[3];          // instructions in EX, MEM, WB (index 0 youngest)
    exp_t sb[$];
    ins_t cur_i;
    bit   cur_stall;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    endtask

    function automatic ins_t mk(int op, int rd, int rs1, int rs2, bit r1u, bit r2u, bit br);
        ins_t i;
        i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.r1u = r1u; i.r2u = r2u; i.br = br;
        return i;
    endfunction

    function automatic bit produces(ent_t e, int rs);
        return rs != 0 && e.rd == rs && (e.op == 1 || e.op == 2);
    endfunction

    function automatic int fwd(bit u, int rs);
        if (!u) return 0;
        if (hist[0].op == 1 && produces(hist[0], rs)) return 1;
        if (hist[1].op == 1 && produces(hist[1], rs)) return 2;
        if (hist[1].op == 2 && produces(hist[1], rs)) return 3;
        return 0;
    endfunction

    function automatic exp_t predict(ins_t i);
        exp_t e;
        bit   stall;
        stall = hist[0].op == 2 &&
                ((i.r1u && produces(hist[0], i.rs1)) ||
                 (i.r2u && i.op != 3 && produces(hist[0], i.rs2)));
        e.pc_en    = !stall;
        e.fd_en    = !stall;
        e.de_flush = stall;
        e.fd_flush = i.br && !stall;
        e.fa       = fwd(i.r1u, i.rs1);
        e.fb       = fwd(i.r2u, i.rs2);
        e.ls       = hist[1].op == 3 && hist[2].op == 2 &&
                     hist[2].rd == hist[1].rs2 && hist[2].rd != 0;
        return e;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0};
    endtask

    task automatic apply(input ins_t i);
        exp_t e;
        rs1use = i.r1u; rs2use = i.r2u; hazard_optype = i.op[1:0];
        rd_ID = i.rd[4:0]; rs1_ID = i.rs1[4:0]; rs2_ID = i.rs2[4:0]; Branch_ID = i.br;
        e = predict(i);
        sb.push_back(e);
        cur_i = i;
        cur_stall = !e.pc_en;
    endtask

    task automatic tick();
        @(posedge clk);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = cur_stall ? '{0, 0, 0} : '{cur_i.op, cur_i.rd, cur_i.rs2};
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc_en"},    PC_EN_IF, 1);
        check({tag, "_fd_en"},    reg_FD_EN, 1);
        check({tag, "_fd_flush"}, reg_FD_flush, 0);
        check({tag, "_de_flush"}, reg_DE_flush, 0);
        check({tag, "_fwd_a"},    forward_ctrl_A, 0);
        check({tag, "_fwd_b"},    forward_ctrl_B, 0);
        check({tag, "_fwd_ls"},   forward_ctrl_ls, 0);
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle against the queue.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_pc_en",    PC_EN_IF, e.pc_en);
            check("sb_fd_en",    reg_FD_EN, e.fd_en);
            check("sb_fd_flush", reg_FD_flush, e.fd_flush);
            check("sb_de_flush", reg_DE_flush, e.de_flush);
            check("sb_fwd_a",    forward_ctrl_A, e.fa);
            check("sb_fwd_b",    forward_ctrl_B, e.fb);
            check("sb_fwd_ls",   forward_ctrl_ls, e.ls);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ins_t i;
        rst = 1'b1; rs1use = 0; rs2use = 0; hazard_optype = 0;
        rd_ID = 0; rs1_ID = 0; rs2_ID = 0; Branch_ID = 0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset");
        @(posedge clk); #1;

        // addi x1,x0,5 ; add x2,x1,x1
        apply(mk(1, 1, 0, 0, 1, 0, 0)); tick();
        apply(mk(1, 2, 1, 1, 1, 1, 0));
        #1 check("alu_fwd_a", forward_ctrl_A, 1);
        check("alu_fwd_b", forward_ctrl_B, 1);
        check("alu_nostall", PC_EN_IF, 1);
        tick();

        // lw x3,0(x0) ; beq x3,x0 (taken) -> one bubble then MEM load forward
        apply(mk(2, 3, 0, 0, 1, 0, 0)); tick();
        i = mk(0, 0, 3, 0, 1, 1, 1);
        apply(i);
        #1 check("lu_pc_en", PC_EN_IF, 0);
        check("lu_de_flush", reg_DE_flush, 1);
        check("lu_br_ignored", reg_FD_flush, 0);
        tick();
        apply(i);
        #1 check("lu_fwd_a", forward_ctrl_A, 3);
        check("lu_released", PC_EN_IF, 1);
        check("lu_br_taken", reg_FD_flush, 1);
        tick();

        // lw x4 ; sw x4,0(x5) -> no stall, store data from WB load two cycles on
        apply(mk(2, 4, 0, 0, 1, 0, 0)); tick();
        apply(mk(3, 0, 5, 4, 1, 1, 0));
        #1 check("st_nostall", PC_EN_IF, 1);
        tick();
        apply(mk(0, 0, 0, 0, 0, 0, 0)); tick();
        apply(mk(0, 0, 0, 0, 0, 0, 0));
        #1 check("st_fwd_ls", forward_ctrl_ls, 1);
        tick();

        // jal with and without a concurrent load-use stall
        apply(mk(1, 1, 0, 0, 0, 0, 1));
        #1 check("jal_flush", reg_FD_flush, 1);
        tick();
        apply(mk(2, 7, 0, 0, 1, 0, 0)); tick();
        i = mk(1, 8, 7, 0, 1, 1, 1);
        apply(i);
        #1 check("jal_stall_flush", reg_FD_flush, 0);
        check("jal_stall_de", reg_DE_flush, 1);
        tick();
        apply(i); tick();

        // x0 destination never forwards
        apply(mk(1, 0, 0, 0, 1, 0, 0)); tick();
        apply(mk(1, 6, 0, 0, 1, 1, 0));
        #1 check("x0_fwd_a", forward_ctrl_A, 0);
        check("x0_fwd_b", forward_ctrl_B, 0);
        check("x0_nostall", PC_EN_IF, 1);
        tick();

        // Reset asserted in the middle of a stall cycle
        apply(mk(2, 9, 0, 0, 1, 0, 0)); tick();
        i = mk(1, 10, 9, 0, 1, 0, 1);
        apply(i);
        #1 check("rst_pre_stall", reg_DE_flush, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
        #1 apply(i);
        #1 check("rst_cleared_nostall", PC_EN_IF, 1);
        check("rst_cleared_br", reg_FD_flush, 1);
        tick();

        // Random streams; a stalled instruction is re-presented as the decoder would
        for (int n = 0; n < 400; n++) begin
            if (!cur_stall) begin
                i.op  = $urandom_range(0, 3);
                i.rd  = $urandom_range(0, 3);
                i.rs1 = $urandom_range(0, 3);
                i.rs2 = $urandom_range(0, 3);
                i.r1u = $urandom_range(0, 1);
                i.r2u = $urandom_range(0, 1);
                if (i.op == 3) begin i.r1u = 1; i.r2u = 1; end
                i.br  = ($urandom_range(0, 5) == 0);
            end
            apply(i);
            tick();
        end

        apply(mk(0, 0, 0, 0, 0, 0, 0)); tick();
        for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
        #1 check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline scheduler for the 5-stage RV32I core: tracks the hazard class and destination register of every in-flight instruction in EX/MEM/WB and, from the decoder's per-instruction use/optype flags, drives stalls, flushes and ID-stage forwarding selects. Branches and jumps resolve in ID, so the block also squashes the wrong-path fetch. It sits beside the decoder and owns every pipeline-register enable/flush in the core.

## Interface
- No parameters; register address width fixed at 5.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rs1use, rs2use  in  1 each  ID instruction reads rs1/rs2
- hazard_optype  in  2  ID class: 00 none, 01 ALU-result, 10 load, 11 store
- rd_ID, rs1_ID, rs2_ID  in  5 each  ID register fields
- Branch_ID  in  1  taken branch/jump resolved in ID
- PC_EN_IF  out  1  PC update enable
- reg_FD_EN, reg_FD_flush  out  1 each  IF/ID enable / clear
- reg_DE_flush  out  1  ID/EX clear (bubble insert)
- forward_ctrl_A, forward_ctrl_B  out  2 each  ID operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
- forward_ctrl_ls  out  1  MEM store data taken from WB load data

## Operation
- Tracker: three {optype, rd} slots EX, MEM, WB. Each cycle: EX <= (stall ? {00,0} : {hazard_optype, rd_ID}); MEM <= EX; WB <= MEM. Always clocked; never held.
- Match(slot, rs) = slot.rd == rs, rs != 0, slot.optype in {01,10}. Stores (11) and none (00) never match.
- load_stall = EX.optype==10 and ((rs1use and Match(EX,rs1_ID)) or (rs2use and Match(EX,rs2_ID) and hazard_optype!=11)). Store rs2 behind a load in EX is not stalled; forward_ctrl_ls covers it.
- stall = load_stall. On stall: PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1, reg_FD_flush=0.
- Branch: if Branch_ID and not stall, reg_FD_flush=1, PC_EN_IF=1. If Branch_ID and stall together, stall wins, branch ignored this cycle (re-evaluated next cycle with forwarded operands).
- Forward select per operand (only when corresponding rsNuse=1, else 00), priority EX over MEM: EX.optype==01 match -> 01; else MEM.optype==01 match -> 10; else MEM.optype==10 match -> 11; else 00. EX load match never forwards (stall covers it).
- forward_ctrl_ls = MEM.optype==11 and WB.optype==10 and WB.rd==rs2 of the store in MEM and WB.rd != 0; store rs2 tracked in an extra 5-bit field of the MEM slot (EX/MEM slots carry rs2 for stores).
- WB needs no forwarding: register file writes in first half-cycle, reads in second.

## Timing
- Tracker state registered; all outputs combinational from tracker state plus current ID inputs, valid same cycle.
- Reset: all slots {00, rd 0, rs2 0}; outputs then PC_EN_IF=1, reg_FD_EN=1, reg_FD_flush=0, reg_DE_flush=0, forward_* = 0. Reset mid-stall drops the stall immediately (async).
- Load-use costs exactly one bubble: cycle N stall, cycle N+1 load in MEM, operand select 11.
- x0 destination or source never matches, never stalls.
- Back-to-back loads to same rd: EX slot younger, priority applies.

## Structure
- core_pkg: optype constants (OP_NONE/ALU/LOAD/STORE), forward select codes (FWD_RF/EX/MEM_ALU/MEM_LD).
- One sub-module: hazard_stage_slot (async-reset register of {optype, rd, rs2}, instantiated for EX, MEM, WB).
- Target 150-250 lines total.

## Test plan
- addi x1,x0,5 then add x2,x1,x1 -> second in ID: forward_ctrl_A=B=01, no stall.
- lw x3,0(x0) then beq x3,x0 -> cycle 1 stall=1 (PC_EN_IF=0, reg_DE_flush=1); cycle 2 forward_ctrl_A=11.
- lw x4 then sw x4,0(x5) -> no stall; two cycles later forward_ctrl_ls=1.
- jal in ID with Branch_ID=1 -> reg_FD_flush=1; with simultaneous load_stall -> flush=0, stall=1.
- addi x0,x0,1 then add x6,x0,x0 -> all forward 00, no stall.
- Assert rst during stall cycle -> all outputs at reset values immediately; slots cleared.
